// File: rtl/pcode_addr_gen_if.sv
// Config handshake and code-address output bundle for the spreading-code NCO.
interface pcode_addr_gen_if #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned EPOCH_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [4:0]         cfg_prn;
    logic [9:0]         cfg_phase;
    logic [ACC_W-1:0]   cfg_fcw;
    logic               stop;
    logic               cfg_err;
    logic               busy;
    logic [15:0]        pcode_addr;
    logic               chip_stb;
    logic               epoch_stb;
    logic [EPOCH_W-1:0] epoch_cnt;
    logic               pcode_vld;

    modport master (
        output cfg_valid, cfg_prn, cfg_phase, cfg_fcw, stop,
        input  cfg_ready, cfg_err, busy, pcode_addr, chip_stb, epoch_stb, epoch_cnt, pcode_vld
    );

    modport slave (
        input  cfg_valid, cfg_prn, cfg_phase, cfg_fcw, stop,
        output cfg_ready, cfg_err, busy, pcode_addr, chip_stb, epoch_stb, epoch_cnt, pcode_vld
    );
endinterface

// File: rtl/pcode_addr_gen.sv
// Code NCO: fractional phase accumulator producing spreading-code ROM addresses,
// chip/epoch strobes and a hitless epoch-aligned config reload.
module pcode_addr_gen #(
    parameter int unsigned CODE_LEN  = 1023,
    parameter int unsigned NUM_BANKS = 20,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned EPOCH_W   = 16
) (
    input  logic clk,
    input  logic rst,
    pcode_addr_gen_if.slave bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned PRN_W  = 5;
    localparam int unsigned CHIP_W = 10;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t              state, state_nxt;
    logic [ACC_W-1:0]    acc, acc_nxt;
    logic [ACC_W-1:0]    fcw, fcw_nxt;
    logic [ADDR_W-1:0]   base, base_nxt;
    logic [CHIP_W-1:0]   chip_idx, chip_idx_nxt;
    logic [ADDR_W-1:0]   pend_base, pend_base_nxt;
    logic [CHIP_W-1:0]   pend_phase, pend_phase_nxt;
    logic [ACC_W-1:0]    pend_fcw, pend_fcw_nxt;
    logic                pend_vld, pend_vld_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic                chip_stb, chip_stb_nxt;
    logic                epoch_stb, epoch_stb_nxt;
    logic [EPOCH_W-1:0]  epoch_cnt, epoch_cnt_nxt;
    logic                pcode_vld, pcode_vld_nxt;
    logic                cfg_err, cfg_err_nxt;

    logic                hs_c, bad_c, ok_c;
    logic [ACC_W:0]      sum_c;
    logic [ADDR_W-1:0]   cfg_base_c;

    assign bus.cfg_ready  = !bus.stop && (state == S_IDLE || (state == S_RUN && !pend_vld));
    assign bus.busy       = (state != S_IDLE);
    assign bus.pcode_addr = addr;
    assign bus.chip_stb   = chip_stb;
    assign bus.epoch_stb  = epoch_stb;
    assign bus.epoch_cnt  = epoch_cnt;
    assign bus.pcode_vld  = pcode_vld;
    assign bus.cfg_err    = cfg_err;

    // prn*1023 as a shift-subtract
    assign cfg_base_c = (ADDR_W'(bus.cfg_prn) << 10) - ADDR_W'(bus.cfg_prn);
    assign hs_c       = bus.cfg_valid && bus.cfg_ready;
    assign bad_c      = (bus.cfg_prn >= PRN_W'(NUM_BANKS)) || (bus.cfg_phase >= CHIP_W'(CODE_LEN));
    assign ok_c       = hs_c && !bad_c;
    assign sum_c      = {1'b0, acc} + {1'b0, fcw};

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        fcw_nxt        = fcw;
        base_nxt       = base;
        chip_idx_nxt   = chip_idx;
        pend_base_nxt  = pend_base;
        pend_phase_nxt = pend_phase;
        pend_fcw_nxt   = pend_fcw;
        pend_vld_nxt   = pend_vld;
        addr_nxt       = addr;
        chip_stb_nxt   = 1'b0;
        epoch_stb_nxt  = 1'b0;
        epoch_cnt_nxt  = epoch_cnt;
        pcode_vld_nxt  = chip_stb;
        cfg_err_nxt    = hs_c && bad_c;

        if (bus.stop) begin
            state_nxt    = S_IDLE;
            pend_vld_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // chip_idx parks the start phase until LOAD publishes it
                    if (ok_c) begin
                        base_nxt     = cfg_base_c;
                        chip_idx_nxt = bus.cfg_phase;
                        fcw_nxt      = bus.cfg_fcw;
                        state_nxt    = S_LOAD;
                    end
                end
                S_LOAD: begin
                    addr_nxt      = base + ADDR_W'(chip_idx);
                    acc_nxt       = '0;
                    chip_stb_nxt  = 1'b1;
                    epoch_cnt_nxt = '0;
                    state_nxt     = S_RUN;
                end
                S_RUN: begin
                    acc_nxt = sum_c[ACC_W-1:0];
                    if (ok_c) begin
                        pend_base_nxt  = cfg_base_c;
                        pend_phase_nxt = bus.cfg_phase;
                        pend_fcw_nxt   = bus.cfg_fcw;
                        pend_vld_nxt   = 1'b1;
                    end
                    if (sum_c[ACC_W]) begin
                        chip_stb_nxt = 1'b1;
                        if (chip_idx == CHIP_W'(CODE_LEN - 1)) begin
                            epoch_stb_nxt = 1'b1;
                            epoch_cnt_nxt = EPOCH_W'(epoch_cnt + 1'b1);
                            // accumulator keeps running across reload for phase continuity
                            if (pend_vld) begin
                                base_nxt     = pend_base;
                                fcw_nxt      = pend_fcw;
                                chip_idx_nxt = pend_phase;
                                addr_nxt     = pend_base + ADDR_W'(pend_phase);
                                pend_vld_nxt = 1'b0;
                            end else begin
                                chip_idx_nxt = '0;
                                addr_nxt     = base;
                            end
                        end else begin
                            chip_idx_nxt = CHIP_W'(chip_idx + 1'b1);
                            addr_nxt     = base + ADDR_W'(CHIP_W'(chip_idx + 1'b1));
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            fcw        <= '0;
            base       <= '0;
            chip_idx   <= '0;
            pend_base  <= '0;
            pend_phase <= '0;
            pend_fcw   <= '0;
            pend_vld   <= 1'b0;
            addr       <= '0;
            chip_stb   <= 1'b0;
            epoch_stb  <= 1'b0;
            epoch_cnt  <= '0;
            pcode_vld  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            fcw        <= fcw_nxt;
            base       <= base_nxt;
            chip_idx   <= chip_idx_nxt;
            pend_base  <= pend_base_nxt;
            pend_phase <= pend_phase_nxt;
            pend_fcw   <= pend_fcw_nxt;
            pend_vld   <= pend_vld_nxt;
            addr       <= addr_nxt;
            chip_stb   <= chip_stb_nxt;
            epoch_stb  <= epoch_stb_nxt;
            epoch_cnt  <= epoch_cnt_nxt;
            pcode_vld  <= pcode_vld_nxt;
            cfg_err    <= cfg_err_nxt;
        end
    end
endmodule

// File: tb/tb_pcode_addr_gen.sv
// Directed bench for pcode_addr_gen with hand-computed expected addresses and strobes.
module tb_pcode_addr_gen;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   stb_seen;

    pcode_addr_gen_if bus ();

    pcode_addr_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [4:0] prn, input logic [9:0] phase, input logic [31:0] fcw);
        bus.cfg_valid = 1'b1;
        bus.cfg_prn   = prn;
        bus.cfg_phase = phase;
        bus.cfg_fcw   = fcw;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst           = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_prn   = '0;
        bus.cfg_phase = '0;
        bus.cfg_fcw   = '0;
        bus.stop      = 1'b0;
        #2;
        chk("rst_addr", 32'(bus.pcode_addr), 0);
        chk("rst_chip_stb", 32'(bus.chip_stb), 0);
        chk("rst_epoch_stb", 32'(bus.epoch_stb), 0);
        chk("rst_vld", 32'(bus.pcode_vld), 0);
        chk("rst_err", 32'(bus.cfg_err), 0);
        chk("rst_epoch_cnt", 32'(bus.epoch_cnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // basic run prn0 phase0 at half chip rate
        offer(5'd0, 10'd0, 32'h8000_0000);
        #1;
        chk("t1_ready", 32'(bus.cfg_ready), 1);
        tick();
        bus.cfg_valid = 1'b0;
        chk("t1_busy_load", 32'(bus.busy), 1);
        chk("t1_load_stb", 32'(bus.chip_stb), 0);
        tick();
        chk("t1_addr0", 32'(bus.pcode_addr), 0);
        chk("t1_stb0", 32'(bus.chip_stb), 1);
        chk("t1_vld0", 32'(bus.pcode_vld), 0);
        tick();
        chk("t1_stb_gap", 32'(bus.chip_stb), 0);
        chk("t1_vld_trail", 32'(bus.pcode_vld), 1);
        chk("t1_addr_hold", 32'(bus.pcode_addr), 0);
        tick();
        chk("t1_addr1", 32'(bus.pcode_addr), 1);
        chk("t1_stb1", 32'(bus.chip_stb), 1);
        tick();
        tick();
        chk("t1_addr2", 32'(bus.pcode_addr), 2);
        tick();
        tick();
        chk("t1_addr3", 32'(bus.pcode_addr), 3);
        chk("t1_epoch_cnt", 32'(bus.epoch_cnt), 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t1_stop_busy", 32'(bus.busy), 0);
        chk("t1_stop_addr", 32'(bus.pcode_addr), 3);
        chk("t1_stop_stb", 32'(bus.chip_stb), 0);
        chk("t1_stop_vld", 32'(bus.pcode_vld), 1);
        tick();
        chk("t1_stop_vld2", 32'(bus.pcode_vld), 0);

        // epoch wrap prn3 from phase 1021
        offer(5'd3, 10'd1021, 32'h8000_0000);
        tick();
        bus.cfg_valid = 1'b0;
        tick();
        chk("t2_addr4090", 32'(bus.pcode_addr), 4090);
        tick();
        tick();
        chk("t2_addr4091", 32'(bus.pcode_addr), 4091);
        chk("t2_no_epoch", 32'(bus.epoch_stb), 0);
        tick();
        tick();
        chk("t2_wrap_addr", 32'(bus.pcode_addr), 3069);
        chk("t2_epoch_stb", 32'(bus.epoch_stb), 1);
        chk("t2_epoch_cnt", 32'(bus.epoch_cnt), 1);
        tick();
        chk("t2_epoch_clr", 32'(bus.epoch_stb), 0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;

        // hitless reload at the epoch boundary
        offer(5'd3, 10'd1021, 32'h8000_0000);
        tick();
        bus.cfg_valid = 1'b0;
        tick();
        chk("t3_addr4090", 32'(bus.pcode_addr), 4090);
        offer(5'd19, 10'd5, 32'h4000_0000);
        #1;
        chk("t3_ready_run", 32'(bus.cfg_ready), 1);
        tick();
        bus.cfg_valid = 1'b0;
        chk("t3_ready_pend", 32'(bus.cfg_ready), 0);
        tick();
        chk("t3_addr4091", 32'(bus.pcode_addr), 4091);
        tick();
        tick();
        chk("t3_reload_addr", 32'(bus.pcode_addr), 19442);
        chk("t3_reload_epoch", 32'(bus.epoch_stb), 1);
        chk("t3_reload_cnt", 32'(bus.epoch_cnt), 1);
        chk("t3_ready_back", 32'(bus.cfg_ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_quarter_gap", 32'(bus.chip_stb), 0);
        end
        tick();
        chk("t3_addr19443", 32'(bus.pcode_addr), 19443);
        chk("t3_stb19443", 32'(bus.chip_stb), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_addr19444", 32'(bus.pcode_addr), 19444);

        // stop wins over a simultaneous config in RUN
        bus.stop = 1'b1;
        offer(5'd1, 10'd0, 32'h8000_0000);
        #1;
        chk("t4_ready_stop", 32'(bus.cfg_ready), 0);
        tick();
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
        chk("t4_busy", 32'(bus.busy), 0);
        stb_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.chip_stb) stb_seen++;
        end
        chk("t4_no_stb", 32'(stb_seen), 0);
        chk("t4_addr_hold", 32'(bus.pcode_addr), 19444);
        chk("t4_busy_idle", 32'(bus.busy), 0);
        chk("t4_ready_idle", 32'(bus.cfg_ready), 1);

        // rejected configs in IDLE
        offer(5'd20, 10'd0, 32'h8000_0000);
        tick();
        bus.cfg_valid = 1'b0;
        chk("t5_err_prn", 32'(bus.cfg_err), 1);
        chk("t5_busy_prn", 32'(bus.busy), 0);
        chk("t5_addr_prn", 32'(bus.pcode_addr), 19444);
        tick();
        chk("t5_err_clr", 32'(bus.cfg_err), 0);
        offer(5'd0, 10'd1023, 32'h8000_0000);
        tick();
        bus.cfg_valid = 1'b0;
        chk("t5_err_phase", 32'(bus.cfg_err), 1);
        chk("t5_busy_phase", 32'(bus.busy), 0);
        tick();
        chk("t5_idle_after", 32'(bus.busy), 0);

        // async reset between edges while running
        offer(5'd2, 10'd10, 32'h8000_0000);
        tick();
        bus.cfg_valid = 1'b0;
        tick();
        chk("t6_addr2056", 32'(bus.pcode_addr), 2056);
        tick();
        tick();
        chk("t6_addr2057", 32'(bus.pcode_addr), 2057);
        chk("t6_stb", 32'(bus.chip_stb), 1);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_rst_addr", 32'(bus.pcode_addr), 0);
        chk("t6_rst_stb", 32'(bus.chip_stb), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_cnt", 32'(bus.epoch_cnt), 0);
        chk("t6_rst_vld", 32'(bus.pcode_vld), 0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("t6_post_busy", 32'(bus.busy), 0);
        chk("t6_post_addr", 32'(bus.pcode_addr), 0);
        chk("t6_post_ready", 32'(bus.cfg_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
